// File: rtl/cpu_core_p_if.sv
// Instruction/data memory handshake bundle for cpu_core_p.
// master = core side, slave = memory/test side.
interface cpu_core_p_if #(
  parameter int DATA_W = 8
);
  logic [31:0]       INSTRUCTION;
  logic              IBUSY;
  logic [31:0]       PC;
  logic              MEM_READ;
  logic              MEM_WRITE;
  logic [7:0]        MEM_ADDR;
  logic [DATA_W-1:0] MEM_WDATA;
  logic [DATA_W-1:0] MEM_RDATA;
  logic              MEM_BUSY;
  logic              ILLEGAL;
  logic [31:0]       INSTRET;

  modport master (
    input  INSTRUCTION, IBUSY, MEM_RDATA, MEM_BUSY,
    output PC, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA, ILLEGAL, INSTRET
  );

  modport slave (
    output INSTRUCTION, IBUSY, MEM_RDATA, MEM_BUSY,
    input  PC, MEM_READ, MEM_WRITE, MEM_ADDR, MEM_WDATA, ILLEGAL, INSTRET
  );
endinterface

// File: rtl/cpu_core_p.sv
// Single-cycle core with busy-wait stalls on instruction and data memory.
// Everything retires at the rising edge where RESET and stall are both low.
module cpu_core_p #(
  parameter int DATA_W = 8,
  parameter int NREG   = 8
) (
  input  logic         CLK,
  input  logic         RESET,
  cpu_core_p_if.master bus
);
  localparam int IW = (NREG > 1) ? $clog2(NREG) : 1;

  typedef enum logic [7:0] {
    OP_LOADI = 8'd0,
    OP_MOV   = 8'd1,
    OP_ADD   = 8'd2,
    OP_SUB   = 8'd3,
    OP_AND   = 8'd4,
    OP_OR    = 8'd5,
    OP_J     = 8'd6,
    OP_BEQ   = 8'd7,
    OP_BNE   = 8'd8,
    OP_LWD   = 8'd9,
    OP_LWI   = 8'd10,
    OP_SWD   = 8'd11,
    OP_SWI   = 8'd12
  } opcode_e;

  logic [31:0]       pc_q, pc_d;
  logic [31:0]       instret_q;
  logic              illegal_q, illegal_d;
  logic [DATA_W-1:0] rf_q [NREG];

  opcode_e           op;
  logic [IW-1:0]     rd_idx, rt_idx, rs_idx;
  logic [DATA_W-1:0] rt_val, rs_val, imm_sext, wb_data;
  logic              wb_en, is_load, is_store;
  logic [7:0]        addr;
  logic [31:0]       pc_plus4, br_target;
  logic              mem_gate, mem_rd, mem_wr, stall;
  logic              unused_instr;

  assign op       = opcode_e'(bus.INSTRUCTION[31:24]);
  assign rd_idx   = bus.INSTRUCTION[16 +: IW];
  assign rt_idx   = bus.INSTRUCTION[8 +: IW];
  assign rs_idx   = bus.INSTRUCTION[0 +: IW];
  assign rt_val   = rf_q[rt_idx];
  assign rs_val   = rf_q[rs_idx];
  assign imm_sext = DATA_W'($signed(bus.INSTRUCTION[7:0]));
  // Register fields wider than IW are ignored by design.
  assign unused_instr = ^bus.INSTRUCTION;

  assign pc_plus4  = pc_q + 32'd4;
  assign br_target = pc_plus4 + {{22{bus.INSTRUCTION[23]}}, bus.INSTRUCTION[23:16], 2'b00};

  always_comb begin
    wb_en     = 1'b0;
    wb_data   = rs_val;
    pc_d      = pc_plus4;
    illegal_d = 1'b0;
    is_load   = 1'b0;
    is_store  = 1'b0;
    addr      = rs_val[7:0];
    case (op)
      OP_LOADI: begin
        wb_en   = 1'b1;
        wb_data = imm_sext;
      end
      OP_MOV: begin
        wb_en   = 1'b1;
        wb_data = rs_val;
      end
      OP_ADD: begin
        wb_en   = 1'b1;
        wb_data = rt_val + rs_val;
      end
      OP_SUB: begin
        wb_en   = 1'b1;
        wb_data = rt_val - rs_val;
      end
      OP_AND: begin
        wb_en   = 1'b1;
        wb_data = rt_val & rs_val;
      end
      OP_OR: begin
        wb_en   = 1'b1;
        wb_data = rt_val | rs_val;
      end
      OP_J:   pc_d = br_target;
      OP_BEQ: if (rt_val == rs_val) pc_d = br_target;
      OP_BNE: if (rt_val != rs_val) pc_d = br_target;
      OP_LWD: begin
        is_load = 1'b1;
        wb_en   = 1'b1;
        wb_data = bus.MEM_RDATA;
      end
      OP_LWI: begin
        is_load = 1'b1;
        wb_en   = 1'b1;
        wb_data = bus.MEM_RDATA;
        addr    = bus.INSTRUCTION[7:0];
      end
      OP_SWD: is_store = 1'b1;
      OP_SWI: begin
        is_store = 1'b1;
        addr     = bus.INSTRUCTION[7:0];
      end
      default: illegal_d = 1'b1;
    endcase
  end

  // Requests only go out for a valid instruction outside reset.
  assign mem_gate = !RESET && !bus.IBUSY;
  assign mem_rd   = is_load && mem_gate;
  assign mem_wr   = is_store && mem_gate;
  assign stall    = bus.IBUSY || ((mem_rd || mem_wr) && bus.MEM_BUSY);

  assign bus.MEM_READ  = mem_rd;
  assign bus.MEM_WRITE = mem_wr;
  assign bus.MEM_ADDR  = addr;
  assign bus.MEM_WDATA = rt_val;
  assign bus.PC        = pc_q;
  assign bus.ILLEGAL   = illegal_q;
  assign bus.INSTRET   = instret_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_q      <= '0;
      instret_q <= '0;
      illegal_q <= 1'b0;
      for (int unsigned i = 0; i < unsigned'(NREG); i++) rf_q[i] <= '0;
    end else if (!stall) begin
      pc_q      <= pc_d;
      instret_q <= instret_q + 32'd1;
      illegal_q <= illegal_d;
      if (wb_en) rf_q[rd_idx] <= wb_data;
    end
  end
endmodule

// File: tb/tb_cpu_core_p.sv
// Bench for cpu_core_p: an 8-bit/8-reg and a 16-bit/16-reg instance driven in turn.
// Register contents are observed through stores checked against a write scoreboard.
module tb_cpu_core_p;
  logic clk = 1'b0;
  logic rst8, rst16;
  logic [31:0] instr;
  logic ibusy, mbusy;
  logic [15:0] rdata;

  int n_checks = 0;
  int n_err    = 0;
  int wr8      = 0;
  int wr16     = 0;
  int w0;
  logic [23:0] q8[$];
  logic [23:0] q16[$];

  cpu_core_p_if #(.DATA_W(8))  b8();
  cpu_core_p_if #(.DATA_W(16)) b16();

  cpu_core_p #(.DATA_W(8), .NREG(8)) dut8 (
    .CLK(clk), .RESET(rst8), .bus(b8.master)
  );
  cpu_core_p #(.DATA_W(16), .NREG(16)) dut16 (
    .CLK(clk), .RESET(rst16), .bus(b16.master)
  );

  assign b8.INSTRUCTION  = instr;
  assign b8.IBUSY        = ibusy;
  assign b8.MEM_BUSY     = mbusy;
  assign b8.MEM_RDATA    = rdata[7:0];
  assign b16.INSTRUCTION = instr;
  assign b16.IBUSY       = ibusy;
  assign b16.MEM_BUSY    = mbusy;
  assign b16.MEM_RDATA   = rdata;

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ins(input logic [7:0] op, input logic [7:0] rd,
                                      input logic [7:0] rt, input logic [7:0] rs);
    return {op, rd, rt, rs};
  endfunction

  // Apply inputs just after a falling edge; a write accepted at the coming
  // rising edge is popped from the scoreboard before that edge.
  task automatic step(input logic [31:0] i, input logic ib, input logic mb, input logic [15:0] rd);
    logic [23:0] e;
    instr = i; ibusy = ib; mbusy = mb; rdata = rd;
    #1;
    if (!rst8 && b8.MEM_WRITE && !mb) begin
      wr8++;
      check("wr8_expected", 32'(q8.size() != 0), 32'd1);
      if (q8.size() != 0) begin
        e = q8.pop_front();
        check("wr8_data", {b8.MEM_ADDR, 8'h00, b8.MEM_WDATA}, e);
      end
    end
    if (!rst16 && b16.MEM_WRITE && !mb) begin
      wr16++;
      check("wr16_expected", 32'(q16.size() != 0), 32'd1);
      if (q16.size() != 0) begin
        e = q16.pop_front();
        check("wr16_data", {b16.MEM_ADDR, b16.MEM_WDATA}, e);
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input logic [31:0] i);
    step(i, 1'b0, 1'b0, 16'h0);
  endtask

  initial begin
    rst8 = 1'b1; rst16 = 1'b1;
    // reset with a load presented: request must stay low
    step(ins(8'd10, 8'd1, 8'd0, 8'h30), 1'b0, 1'b0, 16'h0);
    check("rst_mem_read", 32'(b8.MEM_READ), 32'd0);
    check("rst_pc", b8.PC, 32'd0);
    check("rst_instret", b8.INSTRET, 32'd0);
    check("rst_illegal", 32'(b8.ILLEGAL), 32'd0);
    rst8 = 1'b0;

    run(ins(8'd0, 8'd1, 8'd0, 8'd5));
    run(ins(8'd0, 8'd2, 8'd0, 8'd3));
    run(ins(8'd2, 8'd3, 8'd1, 8'd2));
    run(ins(8'd3, 8'd4, 8'd1, 8'd2));
    check("alu_pc", b8.PC, 32'd16);
    check("alu_instret", b8.INSTRET, 32'd4);

    // store r3 with three busy edges: exactly one accepted write
    q8.push_back({8'h10, 16'd8});
    w0 = wr8;
    for (int k = 0; k < 3; k++) begin
      step(ins(8'd12, 8'd0, 8'd3, 8'h10), 1'b0, 1'b1, 16'h0);
      check("swi_stall_pc", b8.PC, 32'd16);
      check("swi_stall_instret", b8.INSTRET, 32'd4);
      check("swi_stall_wr", 32'(b8.MEM_WRITE), 32'd1);
      check("swi_stall_addr", 32'(b8.MEM_ADDR), 32'h10);
    end
    run(ins(8'd12, 8'd0, 8'd3, 8'h10));
    check("swi_pc", b8.PC, 32'd20);
    check("swi_instret", b8.INSTRET, 32'd5);
    check("swi_one_write", 32'(wr8 - w0), 32'd1);
    q8.push_back({8'h11, 16'd2});
    run(ins(8'd12, 8'd0, 8'd4, 8'h11));

    rst8 = 1'b1;
    run(32'h0);
    rst8 = 1'b0;
    run(ins(8'd0, 8'd1, 8'd0, 8'd7));
    run(ins(8'd0, 8'd2, 8'd0, 8'd7));
    run(ins(8'd7, 8'hFE, 8'd1, 8'd2));
    check("beq_taken_pc", b8.PC, 32'd4);
    run(ins(8'd0, 8'd2, 8'd0, 8'd7));
    run(ins(8'd8, 8'hFE, 8'd1, 8'd2));
    check("bne_fall_pc", b8.PC, 32'd12);
    run(ins(8'd0, 8'd2, 8'd0, 8'd1));
    run(ins(8'd8, 8'h01, 8'd1, 8'd2));
    check("bne_taken_pc", b8.PC, 32'd24);
    run(ins(8'd6, 8'h00, 8'd0, 8'd0));
    check("j_pc", b8.PC, 32'd28);
    check("br_instret", b8.INSTRET, 32'd8);

    // load r5 <= mem[r1] with two busy edges; data sampled at retiring edge
    for (int k = 0; k < 2; k++) begin
      step(ins(8'd9, 8'd5, 8'd0, 8'd1), 1'b0, 1'b1, 16'h0);
      check("lwd_stall_rd", 32'(b8.MEM_READ), 32'd1);
      check("lwd_stall_addr", 32'(b8.MEM_ADDR), 32'd7);
      check("lwd_stall_instret", b8.INSTRET, 32'd8);
    end
    run_load: step(ins(8'd9, 8'd5, 8'd0, 8'd1), 1'b0, 1'b0, 16'h00A5);
    check("lwd_instret", b8.INSTRET, 32'd9);
    check("lwd_pc", b8.PC, 32'd32);
    q8.push_back({8'h20, 16'h00A5});
    run(ins(8'd12, 8'd0, 8'd5, 8'h20));

    step(ins(8'd10, 8'd6, 8'd0, 8'h30), 1'b1, 1'b0, 16'h0);
    check("ibusy_mem_read", 32'(b8.MEM_READ), 32'd0);
    check("ibusy_pc", b8.PC, 32'd36);
    step(ins(8'd10, 8'd6, 8'd0, 8'h30), 1'b0, 1'b0, 16'h003C);
    check("lwi_pc", b8.PC, 32'd40);
    q8.push_back({8'h07, 16'h003C});
    run(ins(8'd11, 8'd0, 8'd6, 8'd1));

    run(ins(8'd4, 8'd7, 8'd6, 8'd1));
    q8.push_back({8'h21, 16'h0004});
    run(ins(8'd12, 8'd0, 8'd7, 8'h21));
    run(ins(8'd5, 8'd0, 8'd6, 8'd1));
    q8.push_back({8'h22, 16'h003F});
    run(ins(8'd12, 8'd0, 8'd0, 8'h22));
    run(ins(8'd3, 8'd7, 8'd2, 8'd1));
    q8.push_back({8'h23, 16'h00FA});
    run(ins(8'd12, 8'd0, 8'd7, 8'h23));
    run(ins(8'd1, 8'd3, 8'd0, 8'd6));
    q8.push_back({8'h24, 16'h003C});
    run(ins(8'd12, 8'd0, 8'd3, 8'h24));

    run(ins(8'hFF, 8'd1, 8'd0, 8'd0));
    check("illegal_flag", 32'(b8.ILLEGAL), 32'd1);
    check("illegal_pc", b8.PC, 32'd80);
    q8.push_back({8'h25, 16'h0007});
    run(ins(8'd12, 8'd0, 8'd1, 8'h25));
    check("illegal_pulse_end", 32'(b8.ILLEGAL), 32'd0);
    check("a_instret", b8.INSTRET, 32'd22);
    check("sb8_empty", 32'(q8.size()), 32'd0);

    rst8 = 1'b1;
    run(32'h0);
    rst16 = 1'b0;
    run(ins(8'd0, 8'h1F, 8'd0, 8'hFF));
    run(ins(8'd2, 8'd15, 8'd15, 8'd15));
    q16.push_back({8'h40, 16'hFFFE});
    run(ins(8'd12, 8'd0, 8'd15, 8'h40));
    check("w16_pc", b16.PC, 32'd12);
    step(ins(8'd9, 8'd3, 8'd0, 8'd15), 1'b0, 1'b1, 16'h1234);
    check("w16_lwd_rd", 32'(b16.MEM_READ), 32'd1);
    check("w16_lwd_addr", 32'(b16.MEM_ADDR), 32'hFE);
    rst16 = 1'b1;
    #1;
    check("w16_rst_drop", 32'(b16.MEM_READ), 32'd0);
    step(ins(8'd9, 8'd3, 8'd0, 8'd15), 1'b0, 1'b1, 16'h1234);
    check("w16_rst_pc", b16.PC, 32'd0);
    check("w16_rst_instret", b16.INSTRET, 32'd0);
    rst16 = 1'b0;
    q16.push_back({8'h41, 16'h0000});
    run(ins(8'd12, 8'd0, 8'd15, 8'h41));
    check("w16_post_pc", b16.PC, 32'd4);
    check("w16_post_instret", b16.INSTRET, 32'd1);
    check("sb16_empty", 32'(q16.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end
endmodule
